// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one byte-enabled data RAM between m0 (CPU) and m1 (loader/debug).
// Optional store trace is enabled by defining DM_TRACE_EN.
module dm_arbiter #(
  parameter int ADDR_W    = 13,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_type,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_type,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, RD} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        id_q, id_d;
  logic [1:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;

  logic        win_id;
  logic        win_we;
  logic [1:0]  win_type;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        misaligned;
  logic [1:0]  gnt, err, rvalid;
  logic [31:0] rdata_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^win_addr[31:ADDR_W+2];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      ptr_q   <= INIT_PRIO;
      id_q    <= 1'b0;
      type_q  <= 2'b00;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      type_q  <= type_d;
      off_q   <= off_d;
    end
  end

  // Everything is gated by clr so outputs drop to zero the moment reset asserts.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    type_d     = type_q;
    off_d      = off_q;
    gnt        = 2'b00;
    err        = 2'b00;
    rvalid     = 2'b00;
    rdata_ext  = 32'h0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    win_id     = (m0_req && m1_req) ? ptr_q : m1_req;
    win_we     = win_id ? m1_we    : m0_we;
    win_type   = win_id ? m1_type  : m0_type;
    win_addr   = win_id ? m1_addr  : m0_addr;
    win_wdata  = win_id ? m1_wdata : m0_wdata;
    misaligned = ((win_type == 2'b00) && (win_addr[1:0] != 2'b00)) ||
                 ((win_type == 2'b11) && win_addr[0]);
    rd_byte    = 8'h00;
    rd_half    = 16'h0000;

    if (!clr) begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt[win_id] = 1'b1;
            ptr_d       = ~win_id;
            if (misaligned) begin
              err[win_id]    = 1'b1;
              rvalid[win_id] = ~win_we;
            end else begin
              mem_en   = 1'b1;
              mem_addr = win_addr[ADDR_W+1:2];
              if (win_we) begin
                mem_we = 1'b1;
                case (win_type)
                  2'b00: begin
                    mem_be    = 4'b1111;
                    mem_wdata = win_wdata;
                  end
                  2'b11: begin
                    mem_be    = win_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{win_wdata[15:0]}};
                  end
                  default: begin
                    mem_be    = 4'b0001 << win_addr[1:0];
                    mem_wdata = {4{win_wdata[7:0]}};
                  end
                endcase
              end else begin
                id_d    = win_id;
                type_d  = win_type;
                off_d   = win_addr[1:0];
                state_d = RD;
              end
            end
          end
        end
        RD: begin
          case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
          endcase
          rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
          case (type_q)
            2'b01:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            2'b10:   rdata_ext = {24'h0, rd_byte};
            2'b11:   rdata_ext = {{16{rd_half[15]}}, rd_half};
            default: rdata_ext = mem_rdata;
          endcase
          rvalid[id_q] = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rvalid[0] ? rdata_ext : 32'h0;
  assign m1_rdata  = rvalid[1] ? rdata_ext : 32'h0;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (mem_en && mem_we)
      $display("%d@m%0d: *%h <= %h be=%b", $time, win_id, {mem_addr, 2'b00}, mem_wdata, mem_be);
  end
`endif

endmodule
